receiver: RTL and testbench
===========================

# receiver

Serial link receiver for the Bomber board link: the stage directly downstream of the link transmitter. It samples the serial bit stream and the end-of-block sync strobe on the link clock and reassembles each 49-bit block into a parallel word. It validates block length and hands complete words to the consumer through a valid/acknowledge handshake. It also flags framing errors and overruns.

## Interface
- WORD_W, 49, bits per block; the transmitter sends index 0 first and index WORD_W-1 last.
- CNT_W, 6, width of the bit counter; must satisfy 2^CNT_W > WORD_W.

- LINK_CLK  in  1  link clock, shared with the transmitter.
- RESET  in  1  synchronous, active-high reset.
- S_IN  in  1  serial data; one bit per LINK_CLK.
- SYNC_IN  in  1  end-of-block strobe; high in the same cycle as the last bit (index WORD_W-1) on S_IN.
- RX_DATA  out  [0:WORD_W-1]  received word; index 0 is the first bit received.
- RX_VALID  out  1  RX_DATA holds an unconsumed word.
- RX_ACK  in  1  consumer pops the word; ignored while RX_VALID=0.
- FRAME_ERR  out  1  one-cycle pulse: a block was discarded as short.
- OVERRUN  out  1  one-cycle pulse: a valid block was dropped because the buffer was full.

## Operation
- Shift register SHREG[0:WORD_W-2] shifts S_IN in every cycle. The newest bit enters at index WORD_W-2.
- Bit counter BITCNT counts S_IN samples since the last SYNC_IN edge. It saturates at 2^CNT_W-1 and is cleared to 0 on every edge where SYNC_IN=1, whether the block is accepted or rejected.
- State machine:
  - S_FILL: BITCNT < WORD_W-1.
  - S_ARMED: BITCNT >= WORD_W-1.
  - Reset enters S_FILL. S_FILL goes to S_ARMED when the count reaches WORD_W-1. Any SYNC_IN returns the machine to S_FILL.
- Edge with SYNC_IN=1 in S_ARMED: the candidate word is {SHREG[0:WORD_W-2], S_IN}.
  - If the buffer has space, the word is written.
  - Otherwise the word is dropped and OVERRUN pulses.
- Edge with SYNC_IN=1 in S_FILL: the word is dropped, FRAME_ERR pulses, and the buffer is unchanged.
- Buffer pop: on an edge with RX_VALID=1 and RX_ACK=1.
- Pop and write on the same edge: both take effect. This never causes an overrun, even when the buffer is full.
- Reset values: RX_DATA=0, RX_VALID=0, FRAME_ERR=0, OVERRUN=0, SHREG=0, BITCNT=0, buffer empty, state S_FILL.
- Reset mid-block: the partial block is lost. A stored but unacked word is lost. The fill sequence restarts.

## Timing
- Latency: a SYNC_IN sampled at edge k gives RX_VALID=1 and the new RX_DATA after edge k (visible in cycle k+1).
- FRAME_ERR and OVERRUN are registered. Each is high for exactly the one cycle after the offending SYNC edge.
- RX_DATA is stable while RX_VALID=1 and no pop occurs.
- Minimum legal SYNC spacing is WORD_W cycles.
- The transmitter sends back-to-back blocks every WORD_W+1 cycles. These must be accepted indefinitely when RX_ACK is tied high.
- The first block after reset is accepted only if at least WORD_W-1 bits preceded its SYNC.

## Configuration
- RECEIVER_DBUF_EN defined: the buffer is a 2-entry FIFO.
  - RX_DATA and RX_VALID reflect the head entry.
  - OVERRUN fires only when both entries are occupied and no pop occurs.
- RECEIVER_DBUF_EN undefined: the buffer is a single holding register.
  - OVERRUN fires when RX_VALID=1 and RX_ACK=0 on a valid SYNC edge.

## Structure
- Shared package bomber_link_pkg holds:
  - WORD_W default constant;
  - the link word typedef logic [0:WORD_W-1];
  - the receiver state encoding (S_FILL, S_ARMED).
- Sub-module rx_buffer (single register or 2-entry FIFO, selected by RECEIVER_DBUF_EN) has these ports:
  - inputs: LINK_CLK, RESET, wr_en, wr_data, rd_en;
  - outputs: rd_data, valid, full.
- The top level keeps SHREG, BITCNT, the state machine and the error pulses.

## Test plan
- After reset, send word 49'h1_2345_6789_ABCD (bit 0 first) with SYNC on the last bit, RX_ACK=1. Expect RX_DATA equal to that word and RX_VALID high for 1 cycle, one cycle after SYNC.
- Send 3 back-to-back blocks (period 50 cycles), RX_ACK=1. Expect 3 words in order, no FRAME_ERR, no OVERRUN.
- Pulse SYNC 20 cycles after reset. Expect a FRAME_ERR pulse and RX_VALID=0. The next full 49-bit block must then be accepted.
- Hold RX_ACK=0 and send 2 blocks, then 3 blocks. Expect the following, and RX_DATA to equal the first word throughout:
  - RECEIVER_DBUF_EN undefined: OVERRUN on the 2nd SYNC.
  - RECEIVER_DBUF_EN defined: no OVERRUN on the 2nd SYNC, OVERRUN on the 3rd.
- Assert RX_ACK in the same cycle as a SYNC edge with the buffer full. Expect no OVERRUN, the old word popped and the new word stored.
- Assert RESET at bit 30 of a block. Expect all outputs at 0. A SYNC 10 cycles after release gives FRAME_ERR, and the next full block is received correctly.

Source files
------------

// File: rtl/bomber_link_pkg.sv
// Shared Bomber link definitions: block width, link word type and receiver state encoding.
package bomber_link_pkg;

  localparam int unsigned WORD_W = 49;

  typedef logic [0:WORD_W-1] link_word_t;

  typedef enum logic {
    S_FILL  = 1'b0,
    S_ARMED = 1'b1
  } rx_state_e;

endpackage

// File: rtl/receiver_if.sv
// Serial-in / parallel-out handshake bundle between link transmitter, receiver and consumer.
interface receiver_if #(
  parameter int unsigned WORD_W = bomber_link_pkg::WORD_W
);

  logic              S_IN;
  logic              SYNC_IN;
  logic              RX_ACK;
  logic [0:WORD_W-1] RX_DATA;
  logic              RX_VALID;
  logic              FRAME_ERR;
  logic              OVERRUN;

  modport master (
    output S_IN, SYNC_IN, RX_ACK,
    input  RX_DATA, RX_VALID, FRAME_ERR, OVERRUN
  );

  modport slave (
    input  S_IN, SYNC_IN, RX_ACK,
    output RX_DATA, RX_VALID, FRAME_ERR, OVERRUN
  );

endinterface

// File: rtl/rx_buffer.sv
// Receive word buffer: single holding register, or a 2-entry FIFO when RECEIVER_DBUF_EN is defined.
module rx_buffer #(
  parameter int unsigned WORD_W = bomber_link_pkg::WORD_W
) (
  input  logic              LINK_CLK,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic [0:WORD_W-1] wr_data,
  input  logic              rd_en,
  output logic [0:WORD_W-1] rd_data,
  output logic              valid,
  output logic              full
);

  logic pop;

`ifdef RECEIVER_DBUF_EN
  logic [0:WORD_W-1] mem [2];
  logic              head;
  logic [1:0]        count;
  logic              wr_idx;

  assign pop    = rd_en && (count != 2'd0);
  // Tail slot is head+count mod 2; with both entries full it aliases the slot being popped.
  assign wr_idx = head ^ count[0];

  always_ff @(posedge LINK_CLK) begin
    if (RESET) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      count  <= '0;
    end else begin
      if (wr_en) mem[wr_idx] <= wr_data;
      if (pop)   head        <= ~head;
      case ({wr_en, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[head];
  assign valid   = (count != 2'd0);
  assign full    = (count == 2'd2);
`else
  logic [0:WORD_W-1] data_q;
  logic              valid_q;

  assign pop = rd_en && valid_q;

  always_ff @(posedge LINK_CLK) begin
    if (RESET) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (wr_en) begin
      data_q  <= wr_data;
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  assign rd_data = data_q;
  assign valid   = valid_q;
  assign full    = valid_q;
`endif

endmodule

// File: rtl/receiver.sv
// Bomber link receiver: deserialises 49-bit blocks framed by SYNC_IN and hands them to the consumer.
// Buffer depth selected by RECEIVER_DBUF_EN (undefined: 1 word, defined: 2 words).
module receiver #(
  parameter int unsigned WORD_W = bomber_link_pkg::WORD_W,
  parameter int unsigned CNT_W  = 6
) (
  input logic       LINK_CLK,
  input logic       RESET,
  receiver_if.slave link
);

  import bomber_link_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] PRE_ARM = CNT_W'(WORD_W - 2);

  logic [0:WORD_W-2] shreg;
  logic [CNT_W-1:0]  bitcnt;
  rx_state_e         state, state_nxt;
  logic [0:WORD_W-1] cand;
  logic              wr_en, full, buf_valid, pop;
  logic              frame_err_nxt, overrun_nxt;
  logic              frame_err_q, overrun_q;

  assign cand = {shreg, link.S_IN};
  assign pop  = buf_valid && link.RX_ACK;

  always_ff @(posedge LINK_CLK) begin
    if (RESET) begin
      shreg       <= '0;
      bitcnt      <= '0;
      state       <= S_FILL;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      shreg       <= {shreg[1:WORD_W-2], link.S_IN};
      if (link.SYNC_IN)          bitcnt <= '0;
      else if (bitcnt != CNT_MAX) bitcnt <= bitcnt + CNT_W'(1);
      state       <= state_nxt;
      frame_err_q <= frame_err_nxt;
      overrun_q   <= overrun_nxt;
    end
  end

  // S_ARMED mirrors BITCNT >= WORD_W-1; the count only drops on SYNC, so arming is one-way until then.
  always_comb begin
    state_nxt     = state;
    wr_en         = 1'b0;
    frame_err_nxt = 1'b0;
    overrun_nxt   = 1'b0;
    if (link.SYNC_IN) begin
      state_nxt = S_FILL;
      if (state == S_ARMED) begin
        if (!full || pop) wr_en       = 1'b1;
        else              overrun_nxt = 1'b1;
      end else begin
        frame_err_nxt = 1'b1;
      end
    end else if (state == S_FILL && bitcnt >= PRE_ARM) begin
      state_nxt = S_ARMED;
    end
  end

  rx_buffer #(
    .WORD_W(WORD_W)
  ) u_buf (
    .LINK_CLK(LINK_CLK),
    .RESET   (RESET),
    .wr_en   (wr_en),
    .wr_data (cand),
    .rd_en   (link.RX_ACK),
    .rd_data (link.RX_DATA),
    .valid   (buf_valid),
    .full    (full)
  );

  assign link.RX_VALID  = buf_valid;
  assign link.FRAME_ERR = frame_err_q;
  assign link.OVERRUN   = overrun_q;

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: random and directed blocks against a queue-based link model.
module tb_receiver;

  import bomber_link_pkg::*;

  localparam int unsigned W = WORD_W;
`ifdef RECEIVER_DBUF_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  receiver_if #(.WORD_W(W)) link ();

  receiver #(.WORD_W(W), .CNT_W(6)) dut (
    .LINK_CLK(clk),
    .RESET   (rst),
    .link    (link)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: bits seen since the last SYNC and the words waiting for the consumer.
  bit         bitq[$];
  link_word_t fifo[$];
  logic       exp_fe, exp_ov, exp_zero;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic s, input logic sync, input logic ack, input logic r);
    link_word_t w;
    logic       pop, acc;
    if (r) begin
      bitq.delete();
      fifo.delete();
      exp_fe   = 1'b0;
      exp_ov   = 1'b0;
      exp_zero = 1'b1;
      return;
    end
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    acc    = 1'b0;
    w      = '0;
    pop    = (fifo.size() > 0) && ack;
    if (sync) begin
      if (bitq.size() >= W - 1) begin
        for (int i = 0; i < int'(W) - 1; i++) w[i] = bitq[bitq.size() - (W - 1) + i];
        w[W-1] = s;
        acc    = 1'b1;
      end else begin
        exp_fe = 1'b1;
      end
      bitq.delete();
    end else begin
      bitq.push_back(s);
      if (bitq.size() > W - 1) void'(bitq.pop_front());
    end
    if (pop) void'(fifo.pop_front());
    if (acc) begin
      if (fifo.size() < DEPTH) begin
        fifo.push_back(w);
        exp_zero = 1'b0;
      end else begin
        exp_ov = 1'b1;
      end
    end
  endtask

  task automatic cycle(input logic s, input logic sync, input logic ack, input logic r);
    rst          = r;
    link.S_IN    = s;
    link.SYNC_IN = sync;
    link.RX_ACK  = ack;
    @(posedge clk);
    model(s, sync, ack, r);
    #1;
    check("valid", 64'(link.RX_VALID), 64'(fifo.size() > 0));
    check("frame_err", 64'(link.FRAME_ERR), 64'(exp_fe));
    check("overrun", 64'(link.OVERRUN), 64'(exp_ov));
    if (fifo.size() > 0)  check("data", 64'(link.RX_DATA), 64'(fifo[0]));
    else if (exp_zero)    check("data_rst", 64'(link.RX_DATA), 64'(0));
  endtask

  task automatic send_block(input link_word_t w, input logic ack, input logic ack_last);
    for (int i = 0; i < int'(W); i++)
      cycle(w[i], (i == int'(W) - 1), (i == int'(W) - 1) ? ack_last : ack, 1'b0);
  endtask

  function automatic link_word_t rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic do_reset(input int unsigned n);
    for (int i = 0; i < int'(n); i++) cycle($urandom_range(0, 1), 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    link_word_t w0, first, wk;
    int unsigned gap, target;

    // Reset state
    do_reset(3);
    check("rst_valid", 64'(link.RX_VALID), 64'(0));
    check("rst_data", 64'(link.RX_DATA), 64'(0));

    // Single known word, one cycle after SYNC
    w0 = 49'h1_2345_6789_ABCD;
    send_block(w0, 1'b1, 1'b1);
    check("t1_data", 64'(link.RX_DATA), 64'(w0));
    check("t1_valid", 64'(link.RX_VALID), 64'(1));
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_popped", 64'(link.RX_VALID), 64'(0));

    // Three back-to-back blocks, period WORD_W+1
    for (int b = 0; b < 3; b++) begin
      send_block(rand_word(), 1'b1, 1'b1);
      cycle($urandom_range(0, 1), 1'b0, 1'b1, 1'b0);
    end

    // Short block after reset, then a good one
    do_reset(2);
    for (int i = 0; i < 19; i++) cycle($urandom_range(0, 1), 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check("t3_fe", 64'(link.FRAME_ERR), 64'(1));
    check("t3_valid", 64'(link.RX_VALID), 64'(0));
    send_block(rand_word(), 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Consumer stalled: 2 blocks, then 3 more
    first = rand_word();
    send_block(first, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    send_block(rand_word(), 1'b0, 1'b0);
    check("t4_ov2", 64'(link.OVERRUN), 64'(DEPTH == 1));
    check("t4_head2", 64'(link.RX_DATA), 64'(first));
    for (int b = 0; b < 3; b++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      send_block(rand_word(), 1'b0, 1'b0);
      check("t4_ov", 64'(link.OVERRUN), 64'(1));
      check("t4_head", 64'(link.RX_DATA), 64'(first));
    end

    // Pop on the same edge as a SYNC into a full buffer
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    wk = rand_word();
    send_block(wk, 1'b0, 1'b1);
    check("t5_ov", 64'(link.OVERRUN), 64'(0));
    check("t5_tail", 64'(fifo[fifo.size()-1]), 64'(wk));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-block at bit 30
    wk = rand_word();
    for (int i = 0; i < 30; i++) cycle(wk[i], 1'b0, 1'b0, 1'b0);
    do_reset(2);
    check("t6_valid", 64'(link.RX_VALID), 64'(0));
    check("t6_data", 64'(link.RX_DATA), 64'(0));
    check("t6_fe", 64'(link.FRAME_ERR), 64'(0));
    check("t6_ov", 64'(link.OVERRUN), 64'(0));
    for (int i = 0; i < 9; i++) cycle($urandom_range(0, 1), 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("t6_fe_sync", 64'(link.FRAME_ERR), 64'(1));
    send_block(rand_word(), 1'b1, 1'b1);

    // Long gap past the counter range before SYNC
    for (int i = 0; i < 100; i++) cycle($urandom_range(0, 1), 1'b0, 1'b1, 1'b0);
    cycle($urandom_range(0, 1), 1'b1, 1'b1, 1'b0);
    check("t7_valid", 64'(link.RX_VALID), 64'(1));

    // Random traffic: random SYNC spacing and consumer stalls
    gap    = 0;
    target = $urandom_range(10, 80);
    for (int i = 0; i < 1500; i++) begin
      if (gap >= target) begin
        cycle($urandom_range(0, 1), 1'b1, ($urandom_range(0, 3) != 0), 1'b0);
        gap    = 0;
        target = $urandom_range(10, 80);
      end else begin
        cycle($urandom_range(0, 1), 1'b0, ($urandom_range(0, 3) != 0), 1'b0);
        gap++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
